wave_recorder: RTL and testbench

Sample-capture memory for the signal generator: the write-side counterpart of the synchronous waveform ROM. It arms on command, waits for an optional rising level crossing on the incoming sample stream, then records consecutive samples into an internal 2^ADDRESS_WIDTH-deep RAM. The captured buffer is read back through a synchronous address/data port with the same one-cycle latency as the waveform ROM, so existing address-counter logic can replay it.

---
 rtl/wave_recorder.sv | 93 +++++++++
 tb/tb_wave_recorder.sv | 121 ++++++++++++
 2 files changed

// File: rtl/wave_recorder.sv
// wave_recorder: armed, optionally level-triggered sample capture RAM with a synchronous readback port
module wave_recorder #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     trig_en,
  input  logic [DATA_WIDTH-1:0]    trig_level,
  input  logic                     en,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_dout,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH:0]   count
);
  typedef enum logic [1:0] {IDLE, ARMED, RECORD, DONE} state_t;
  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d, wa;
  logic [ADDRESS_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0]    prev_sample_q, prev_sample_d, rd_dout_q;
  logic                     prev_valid_q, prev_valid_d, busy_q, busy_d, done_q, done_d, we, trig;
  logic [DATA_WIDTH-1:0]    mem [2**ADDRESS_WIDTH];
  assign trig = en && prev_valid_q && prev_sample_q < trig_level && din >= trig_level;
  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    count_d       = count_q;
    prev_sample_d = prev_sample_q;
    prev_valid_d  = prev_valid_q;
    we            = 1'b0;
    wa            = wr_addr_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d      = trig_en ? ARMED : RECORD;
        wr_addr_d    = '0;
        count_d      = '0;
        prev_valid_d = 1'b0;
      end
      ARMED: if (stop) state_d = DONE;
      else if (en) begin
        prev_sample_d = din;
        prev_valid_d  = 1'b1;
        if (trig) begin
          we        = 1'b1;
          wa        = '0;
          wr_addr_d = ADDRESS_WIDTH'(1);
          count_d   = (ADDRESS_WIDTH+1)'(1);
          state_d   = RECORD;
        end
      end
      default: if (stop) state_d = DONE;
      else if (en) begin
        we        = 1'b1;
        wr_addr_d = wr_addr_q + 1'b1;
        count_d   = count_q + 1'b1;
        state_d   = &wr_addr_q ? DONE : RECORD;
      end
    endcase
    busy_d = state_d == ARMED || state_d == RECORD;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      count_q       <= '0;
      prev_sample_q <= '0;
      prev_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_dout_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      count_q       <= count_d;
      prev_sample_q <= prev_sample_d;
      prev_valid_q  <= prev_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rd_dout_q     <= mem[rd_addr];
    end
  end
  // RAM has no reset; a write pending in a reset cycle is dropped with the capture
  always_ff @(posedge clk) if (we && !rst) mem[wa] <= din;
  assign rd_dout = rd_dout_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign count   = count_q;
endmodule

// File: tb/tb_wave_recorder.sv
// tb_wave_recorder: table-driven directed check of wave_recorder with ADDRESS_WIDTH=4
module tb_wave_recorder;
  logic       clk = 0, rst = 1, start = 0, stop = 0, trig_en = 0, en = 0;
  logic [7:0] trig_level = 0, din = 0, rd_dout;
  logic [3:0] rd_addr = 0;
  logic       busy, done;
  logic [4:0] count;
  int checks = 0, errors = 0;

  wave_recorder #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .trig_en(trig_en),
    .trig_level(trig_level), .en(en), .din(din), .rd_addr(rd_addr),
    .rd_dout(rd_dout), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, st, sp, te, e;
    logic [7:0] l, d;
    logic [3:0] a;
    logic       eb, ed;
    logic [4:0] ec;
    logic       cr;
    logic [7:0] er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic st, logic sp, logic te, logic e, logic [7:0] l,
                              logic [7:0] d, logic [3:0] a, logic eb, logic ed,
                              logic [4:0] ec, logic cr, logic [7:0] er);
    vec_t v;
    v.r = r; v.st = st; v.sp = sp; v.te = te; v.e = e; v.l = l; v.d = d; v.a = a;
    v.eb = eb; v.ed = ed; v.ec = ec; v.cr = cr; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    rst = v.r; start = v.st; stop = v.sp; trig_en = v.te; en = v.e;
    trig_level = v.l; din = v.d; rd_addr = v.a;
    @(posedge clk);
    #1;
    chk({tag, " busy"}, 32'(busy), 32'(v.eb));
    chk({tag, " done"}, 32'(done), 32'(v.ed));
    chk({tag, " count"}, 32'(count), 32'(v.ec));
    if (v.cr) chk({tag, " rd_dout"}, 32'(rd_dout), 32'(v.er));
  endtask

  function automatic void rec(logic [7:0] d, logic [4:0] c, logic last);
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, d, 0, !last, last, c, 0, 0));
  endfunction

  function automatic void rb(logic [3:0] a, logic [4:0] c, logic [7:0] er);
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'hFF, a, 0, 1, c, 1, er));
  endfunction

  initial begin
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) rec(8'(8'h10 + i), 5'(i + 1), i == 15);
    for (int i = 0; i < 16; i++) rb(4'(i), 16, 8'(8'h10 + i));
    tbl.push_back(mk(0, 1, 0, 1, 0, 8'h80, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'h80, 8'h90, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'h80, 8'h70, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'h80, 8'h7F, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'h80, 8'h80, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'h80, 8'h81, 0, 1, 0, 2, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 8'h80, 0, 0, 0, 1, 2, 0, 0));
    rb(0, 2, 8'h80); rb(1, 2, 8'h81); rb(2, 2, 8'h12);
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) rec(8'(8'h30 + i), 5'(i + 1), 0);
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 8'hAA, 0, 0, 1, 5, 0, 0));
    rb(4, 5, 8'h34); rb(5, 5, 8'h15);
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'h41, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h42, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h43, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 8'h44, 0, 1, 0, 2, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
    rb(0, 2, 8'h41); rb(1, 2, 8'h44); rb(2, 2, 8'h32);
    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // read/write collision on address 3 (old contents 0x22)
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "c_start");
    apply(mk(0, 0, 0, 0, 1, 0, 8'h70, 0, 1, 0, 1, 0, 0), "c_w0");
    apply(mk(0, 0, 0, 0, 1, 0, 8'h71, 0, 1, 0, 2, 0, 0), "c_w1");
    apply(mk(0, 0, 0, 0, 1, 0, 8'h72, 0, 1, 0, 3, 0, 0), "c_w2");
    apply(mk(0, 0, 0, 0, 1, 0, 8'h22, 0, 1, 0, 4, 0, 0), "c_w3");
    apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0), "c_stop");
    apply(mk(0, 1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1, 8'h22), "c_restart");
    apply(mk(0, 0, 0, 0, 1, 0, 8'h01, 3, 1, 0, 1, 1, 8'h22), "c_x0");
    apply(mk(0, 0, 0, 0, 1, 0, 8'h02, 3, 1, 0, 2, 1, 8'h22), "c_x1");
    apply(mk(0, 0, 0, 0, 1, 0, 8'h03, 3, 1, 0, 3, 1, 8'h22), "c_x2");
    apply(mk(0, 0, 0, 0, 1, 0, 8'h55, 3, 1, 0, 4, 1, 8'h22), "c_collide");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 4, 1, 8'h55), "c_after");

    // reset after 7 writes, then a fresh capture from address 0
    apply(mk(0, 0, 0, 0, 1, 0, 8'h06, 0, 1, 0, 5, 0, 0), "r_w4");
    apply(mk(0, 0, 0, 0, 1, 0, 8'h07, 0, 1, 0, 6, 0, 0), "r_w5");
    apply(mk(0, 0, 0, 0, 1, 0, 8'h08, 0, 1, 0, 7, 0, 0), "r_w6");
    apply(mk(1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 8'h00), "r_rst");
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "r_start");
    apply(mk(0, 0, 0, 0, 1, 0, 8'h99, 0, 1, 0, 1, 0, 0), "r_w0");
    apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), "r_stop");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 8'h99), "r_rb0");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 8'h02), "r_rb1");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 6, 0, 1, 1, 1, 8'h08), "r_rb6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
